// File: rtl/chunk_stream_reg_if.sv
// Stream bus for chunk_stream_reg: block load side and word output side.
// STREAM_ROTATE_EN adds the reps field sampled with each accepted block.
interface chunk_stream_reg_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int IDX_W = 6,
    parameter int REP_W = 4
);
    logic                     load;
    logic [0:WIDTH*DEPTH-1]   in;
`ifdef STREAM_ROTATE_EN
    logic [REP_W-1:0]         reps;
`endif
    logic                     out_ready;
    logic [0:WIDTH-1]         out;
    logic                     out_valid;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;

    modport master (
        input  load,
        input  in,
`ifdef STREAM_ROTATE_EN
        input  reps,
`endif
        input  out_ready,
        output out,
        output out_valid,
        output out_idx,
        output out_last
    );

    modport slave (
        output load,
        output in,
`ifdef STREAM_ROTATE_EN
        output reps,
`endif
        output out_ready,
        input  out,
        input  out_valid,
        input  out_idx,
        input  out_last
    );
endinterface

// File: rtl/chunk_stream_reg.sv
// Wide-load block register streamed out one word per beat over valid/ready.
// Define STREAM_ROTATE_EN for multi-pass rotate mode with a reps input.
module chunk_stream_reg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int IDX_W = 6,
    parameter int REP_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    chunk_stream_reg_if.master    bus,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [0:WIDTH*DEPTH-1] storage;
    logic [IDX_W-1:0]       idx;
    logic                   xfer;
    logic                   at_end;
    logic                   final_beat;
    logic                   accept;
    logic [0:WIDTH-1]       tail;

`ifdef STREAM_ROTATE_EN
    logic [REP_W-1:0]       pass;
    logic [REP_W-1:0]       reps_q;
    assign at_end = (idx == LAST_IDX) && (pass == reps_q);
    assign tail   = storage[0:WIDTH-1];
`else
    assign at_end = (idx == LAST_IDX);
    assign tail   = '0;
`endif

    assign xfer       = bus.out_valid && bus.out_ready;
    assign final_beat = xfer && at_end;
    assign accept     = bus.load && (state == IDLE || final_beat);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (accept) state_nxt = STREAM;
            STREAM: if (final_beat && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state == STREAM);
        busy          = (state == STREAM);
        bus.out       = bus.out_valid ? storage[0:WIDTH-1] : '0;
        bus.out_idx   = idx;
        bus.out_last  = bus.out_valid && at_end;
    end

    // A beat shifts the head away; the tail is zero-filled or, in rotate
    // mode, refilled with the word that just left.
    always_ff @(posedge clk) begin
        if (rst) begin
            storage <= '0;
            idx     <= '0;
            done    <= 1'b0;
`ifdef STREAM_ROTATE_EN
            pass    <= '0;
            reps_q  <= '0;
`endif
        end else begin
            done <= final_beat;
            if (accept) begin
                storage <= bus.in;
                idx     <= '0;
`ifdef STREAM_ROTATE_EN
                pass    <= '0;
                reps_q  <= bus.reps;
`endif
            end else if (xfer) begin
                storage <= {storage[WIDTH:WIDTH*DEPTH-1], tail};
                if (idx == LAST_IDX) begin
                    idx <= '0;
`ifdef STREAM_ROTATE_EN
                    pass <= pass + REP_W'(1);
`endif
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_chunk_stream_reg.sv
// Directed bench for chunk_stream_reg with WIDTH=8, DEPTH=4.
// Rotate-mode steps run only when STREAM_ROTATE_EN is defined.
module tb_chunk_stream_reg;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;
    localparam int REP_W = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic done;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    chunk_stream_reg_if #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .REP_W(REP_W)
    ) bus ();

    chunk_stream_reg #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .REP_W(REP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // head word, index, last, valid, busy, done
    task automatic chk_beat(input string tag, input logic [7:0] w,
                            input logic [1:0] i, input logic l,
                            input logic v, input logic b, input logic d);
        chk({tag, ".out"}, 32'(bus.out), 32'(w));
        chk({tag, ".idx"}, 32'(bus.out_idx), 32'(i));
        chk({tag, ".last"}, 32'(bus.out_last), 32'(l));
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    initial begin
        rst = 1'b1;
        bus.load = 1'b0;
        bus.in = '0;
        bus.out_ready = 1'b0;
`ifdef STREAM_ROTATE_EN
        bus.reps = '0;
`endif
        step();
        step();
        rst = 1'b0;
        chk_beat("reset", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // single block, ready held high
        bus.in = 32'h11223344;
        bus.load = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.load = 1'b0;
        chk_beat("t1.b0", 8'h11, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t1.b1", 8'h22, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t1.b2", 8'h33, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t1.b3", 8'h44, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t1.done", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_beat("t1.idle", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // backpressure on 0x22, then back-to-back reload on 0x44
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk_beat("t2.b0", 8'h11, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_beat("t2.hold", 8'h22, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        bus.out_ready = 1'b1;
        step();
        chk_beat("t2.b2", 8'h33, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t2.b3", 8'h44, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.in = 32'hAABBCCDD;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk_beat("t3.b0", 8'hAA, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        chk_beat("t3.b1", 8'hBB, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t3.b2", 8'hCC, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t3.b3", 8'hDD, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t3.done", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // load while mid-stream is ignored
        bus.in = 32'h11223344;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        chk_beat("t4.b1", 8'h22, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        bus.in = 32'h55667788;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk_beat("t4.b2", 8'h33, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t4.b3", 8'h44, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t4.done", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_beat("t4.idle", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset while 0x33 is the head
        bus.in = 32'h11223344;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        step();
        chk_beat("t5.b2", 8'h33, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_beat("t5.rst", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_beat("t5.nodone", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk_beat("t5.b0", 8'h11, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        step();
        step();
        chk_beat("t5.b3", 8'h44, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t5.done", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef STREAM_ROTATE_EN
        // two passes over the same block
        bus.reps = 2'd1;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.reps = 2'd0;
        chk_beat("t6.b0", 8'h11, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t6.b1", 8'h22, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t6.b2", 8'h33, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t6.b3", 8'h44, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t6.b4", 8'h11, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t6.b5", 8'h22, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t6.b6", 8'h33, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t6.b7", 8'h44, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_beat("t6.done", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/chunk_stream_reg.md
Name: chunk_stream_reg

Overview:
- Parametrised successor to the team's wide-load/chunk-shift register used to feed matrix rows or columns into the multiplier datapath.
- Loads a DEPTH-word block in one cycle, then streams it out one WIDTH-bit word per beat through a valid/ready handshake.
- Adds beat index, last/done flags, backpressure, back-to-back reload and an optional multi-pass rotate mode.

Parameters:
WIDTH, 32, bits per word streamed out.
DEPTH, 64, words per loaded block (>=2).
IDX_W, 6, index width; must satisfy 2**IDX_W >= DEPTH.
REP_W, 4, pass-count width (used only with STREAM_ROTATE_EN).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
load  input  1  capture `in` when the block is accepting.
in  input  [0:WIDTH*DEPTH-1]  block; word k = in[k*WIDTH : k*WIDTH+WIDTH-1], word 0 streamed first.
out_ready  input  1  downstream can take a word this cycle.
out  output  [0:WIDTH-1]  current head word; 0 when out_valid=0.
out_valid  output  1  head word valid.
out_idx  output  [IDX_W-1:0]  index (0..DEPTH-1) of the current head word.
out_last  output  1  head word is the final beat of the block/stream.
busy  output  1  high in STREAM.
done  output  1  one-cycle pulse the cycle after the final beat transfers.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high on rst.
- Reset values: state=IDLE, storage=0, out=0, out_valid=0, out_idx=0, out_last=0, busy=0, done=0.
- Reset mid-stream aborts the stream. No done pulse is produced.
- States: IDLE and STREAM.
- Transfer: a beat transfers on an edge where out_valid && out_ready.
- Accept condition: accept = load && (state==IDLE || final beat transfers this cycle).
- Load in STREAM other than on the final-beat edge is ignored. The current stream is unaffected.
- IDLE -> STREAM on accept. Storage <= in, idx <= 0.
- Latency: first word appears on out with out_valid=1 in the cycle after the accepting edge.
- STREAM, beat transfers and it is not final:
  - storage shifts left one word: storage <= {storage[WIDTH:end], WIDTH'd0}
  - idx <= idx+1
- STREAM, beat held (out_ready=0): out, out_idx and out_last hold stable. Valid never drops without a transfer.
- Final beat: the transfer with idx==DEPTH-1 (no rotate).
  - If it transfers without accept: -> IDLE, done=1 next cycle.
  - If it transfers with accept: stay in STREAM, storage <= new block, idx <= 0, done=1 next cycle. Back-to-back streams have no bubble.
- out_last = out_valid && (idx==DEPTH-1) in single-pass mode.
- out is driven combinationally from the head word of storage, gated by out_valid.
- Throughput: 1 word/cycle with out_ready held high. DEPTH beats per block.

Optional Feature:
STREAM_ROTATE_EN
- Defined:
  - Adds input port reps [REP_W-1:0], sampled on accept.
  - Each transferred word is rotated back to the tail instead of being zero-filled: storage <= {storage[WIDTH:end], storage[0:WIDTH-1]}.
  - The stream runs (reps+1) passes, i.e. DEPTH*(reps+1) beats. out_idx wraps DEPTH-1 -> 0 between passes.
  - A pass counter resets to 0 on accept.
  - out_last and the final-beat condition require idx==DEPTH-1 && pass==reps.
  - reps=0 behaves exactly as single-pass.
- Undefined: no reps port, no pass counter. Zero-fill single pass exactly as in Behaviour.

Test Plan:
1. WIDTH=8, DEPTH=4, rst 2 cycles, then load in=0x11223344 with out_ready=1 -> out 0x11,0x22,0x33,0x44 on cycles 1-4 after load; out_idx 0..3; out_last only with 0x44; done pulse cycle 5; busy low cycle 5.
2. Backpressure: same load, out_ready=0 for 3 cycles while 0x22 is the head -> out=0x22, idx=1, valid=1 held all 3 cycles; then 0x33 follows with no word lost or repeated.
3. Back-to-back: assert load with in=0xAABBCCDD on the edge where 0x44 transfers -> next cycle out=0xAA, idx=0, busy=1, done=1 in the same cycle; total 8 beats with no gap.
4. Load ignored: assert load with 0x55667788 while 0x22 is the head (not final) -> stream continues 0x33,0x44; IDLE afterwards; 0x55 never appears.
5. Reset mid-stream: rst=1 while 0x33 is the head -> next cycle out=0, out_valid=0, busy=0, out_idx=0, no done pulse; a subsequent load streams normally from word 0.
6. STREAM_ROTATE_EN, reps=1, in=0x11223344 -> 8 beats 0x11,0x22,0x33,0x44,0x11,0x22,0x33,0x44; idx 0..3,0..3; out_last only on the 8th beat; done after the 8th.
